mem_sequencer: RTL and testbench

Sequences the single shared memory bus for the single-cycle core. The cycle for each instruction is: fetch the instruction at PCaddr, latch it, then perform at most one data access when decode requests one. The block then issues a one-cycle iready commit pulse, which advances the PC and qualifies all architectural writes. It sits between the PC, the control unit and datapath, and the external memory bus.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/bus_timer.sv | 32 +++
 rtl/mem_sequencer.sv | 118 +++++++++++
 tb/tb_mem_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: memory sequencer state encoding and the reset-time instruction.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    HALTED = 3'd3,
    ERROR  = 3'd4
  } seq_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/bus_timer.sv
// Bus wait counter: counts unacknowledged request cycles and flags the cycle
// in which the count would reach TIMEOUT_CYC (TIMEOUT_CYC = 0 never expires).
module bus_timer #(
  parameter int TIMEOUT_CYC = 0
) (
  input  logic clk,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Fires in the wait cycle that takes the count to the limit; an ack that
  // cycle drops inc, so the ack wins.
  assign expired = (TIMEOUT_CYC != 0) && inc && (count == LAST);

endmodule

// File: rtl/mem_sequencer.sv
// Shared memory bus sequencer for the single-cycle core: fetch, optional data
// access, then a one-cycle iready commit.
// Bus handshake: bus_req holds with stable addr/we/wdata/be until the cycle
// bus_ack is high; that cycle completes the access. bus_ack without bus_req is ignored.
module mem_sequencer #(
  parameter int          TIMEOUT_CYC = 0,
  parameter logic [31:0] NOP_INSTR   = cpu_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                nRST,
  input  logic [31:0]         PCaddr,
  output logic [31:0]         instr,
  output logic                iready,
  input  logic                dmem_read,
  input  logic                dmem_write,
  input  logic [31:0]         dmem_addr,
  input  logic [31:0]         dmem_wdata,
  input  logic [3:0]          dmem_be,
  output logic [31:0]         drdata,
  output logic                dvalid,
  input  logic                halt,
  output logic                halted,
  output logic                bus_req,
  output logic                bus_we,
  output logic [31:0]         bus_addr,
  output logic [31:0]         bus_wdata,
  output logic [3:0]          bus_be,
  input  logic [31:0]         bus_rdata,
  input  logic                bus_ack,
  output logic                bus_err,
  output cpu_pkg::seq_state_t seq_state
);

  import cpu_pkg::*;

  seq_state_t state, state_next;
  logic       mem_op;
  logic       instr_load;
  logic       timer_inc;
  logic       timer_clr;
  logic       expired;

  assign mem_op    = dmem_read | dmem_write;
  assign timer_inc = bus_req & ~bus_ack;
  assign timer_clr = bus_ack | (state_next != state);

  bus_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .nRST   (nRST),
    .inc    (timer_inc),
    .clr    (timer_clr),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      instr <= NOP_INSTR;
    end else begin
      state <= state_next;
      if (instr_load) instr <= bus_rdata;
    end
  end

  always_comb begin
    state_next = state;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = PCaddr;
    bus_wdata  = dmem_wdata;
    bus_be     = 4'hF;
    iready     = 1'b0;
    dvalid     = 1'b0;
    instr_load = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        bus_req = 1'b1;
        if (bus_ack) begin
          instr_load = 1'b1;
          state_next = EXEC;
        end else if (expired) begin
          state_next = ERROR;
        end
      end
      EXEC: begin
        if (!mem_op) begin
          iready     = 1'b1;
          state_next = halt ? HALTED : FETCH;
        end else begin
          bus_req  = 1'b1;
          bus_we   = dmem_write;
          bus_addr = dmem_addr;
          bus_be   = dmem_be;
          if (bus_ack) begin
            iready     = 1'b1;
            // A simultaneous read+write request is treated as a store.
            dvalid     = dmem_read & ~dmem_write;
            state_next = halt ? HALTED : FETCH;
          end else if (expired) begin
            state_next = ERROR;
          end
        end
      end
      HALTED: state_next = HALTED;
      ERROR:  state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  assign halted    = (state == HALTED);
  assign bus_err   = (state == ERROR);
  assign drdata    = bus_rdata;
  assign seq_state = state;

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: scenario tasks with inline checks plus
// a commit monitor scoring instr/drdata against expected queues.
module tb_mem_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] PCaddr = '0;
  logic [31:0] instr;
  logic        iready;
  logic        dmem_read = 1'b0;
  logic        dmem_write = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [3:0]  dmem_be = 4'hF;
  logic [31:0] drdata;
  logic        dvalid;
  logic        halt = 1'b0;
  logic        halted;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        bus_err;
  seq_state_t  seq_state;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] mon_e;
  logic [31:0] pc;

  always #5 clk = ~clk;

  mem_sequencer #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .nRST(nRST), .PCaddr(PCaddr), .instr(instr), .iready(iready),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .drdata(drdata), .dvalid(dvalid),
    .halt(halt), .halted(halted), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err), .seq_state(seq_state)
  );

  // Commit monitor: every iready must match an expected instruction, every dvalid a load value.
  always @(negedge clk) begin
    if (nRST && iready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: instr=%h with no commit expected", instr);
      end else begin
        mon_e = exp_q.pop_front();
        if (instr !== mon_e) begin
          errors++;
          $display("FAIL commit_instr: got %h expected %h", instr, mon_e);
        end
      end
    end
    if (nRST && dvalid) begin
      checks++;
      if (d_exp_q.size() == 0) begin
        errors++;
        $display("FAIL dvalid_unexpected: drdata=%h", drdata);
      end else begin
        mon_e = d_exp_q.pop_front();
        if (drdata !== mon_e) begin
          errors++;
          $display("FAIL load_data: got %h expected %h", drdata, mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_req, iready, dvalid, halted, bus_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: req/iready/dvalid/halted/err=%b expected 00000",
               {bus_req, iready, dvalid, halted, bus_err});
    end
    checks++;
    if (instr !== 32'h13 || seq_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: instr=%h state=%0d expected 00000013/IDLE", instr, seq_state);
    end
  endtask

  task automatic test_alu();
    pc = 0; PCaddr = pc; bus_ack = 1'b1; bus_rdata = 32'h0050_0093;
    @(posedge clk); #1;
    nRST = 1'b1; #1;
    checks++;
    if (bus_req !== 1'b0 || seq_state !== IDLE) begin
      errors++; $display("FAIL alu_cycle0: req=%b state=%0d expected 0/IDLE", bus_req, seq_state);
    end
    tick();
    exp_q.push_back(32'h0050_0093); #1;
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_be} !== {1'b1, 1'b0, 32'h0, 4'hF}) begin
      errors++; $display("FAIL alu_fetch: req=%b we=%b addr=%h be=%h expected 1/0/0/f",
                         bus_req, bus_we, bus_addr, bus_be);
    end
    tick(); #1;
    checks++;
    if ({instr, iready, bus_req} !== {32'h0050_0093, 1'b1, 1'b0}) begin
      errors++; $display("FAIL alu_exec: instr=%h iready=%b req=%b expected 00500093/1/0",
                         instr, iready, bus_req);
    end
    tick(); pc = 4; PCaddr = pc; #1;
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h4) begin
      errors++; $display("FAIL alu_next_fetch: req=%b addr=%h expected 1/4", bus_req, bus_addr);
    end
  endtask

  task automatic test_load();
    bus_ack = 1'b1; bus_rdata = 32'h1000_2083; exp_q.push_back(32'h1000_2083);
    dmem_read = 1'b1; dmem_addr = 32'h100; dmem_be = 4'hF;
    tick();
    bus_ack = 1'b0; bus_rdata = '0;
    for (int w = 0; w < 3; w++) begin
      #1;
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_be, iready, dvalid} !== {1'b1, 1'b0, 32'h100, 4'hF, 2'b00}) begin
        errors++; $display("FAIL load_wait%0d: req=%b we=%b addr=%h be=%h iready=%b dvalid=%b",
                           w, bus_req, bus_we, bus_addr, bus_be, iready, dvalid);
      end
      tick();
    end
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; d_exp_q.push_back(32'hDEAD_BEEF); #1;
    checks++;
    if ({bus_req, iready, dvalid, drdata} !== {3'b111, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL load_ack: req=%b iready=%b dvalid=%b drdata=%h expected 1/1/1/deadbeef",
                         bus_req, iready, dvalid, drdata);
    end
    tick(); dmem_read = 1'b0; pc += 4; PCaddr = pc; #1;
    checks++;
    if (seq_state !== FETCH || bus_addr !== pc) begin
      errors++; $display("FAIL load_next: state=%0d addr=%h expected FETCH/%h", seq_state, bus_addr, pc);
    end
  endtask

  task automatic test_store();
    bus_ack = 1'b1; bus_rdata = 32'h0011_2023; exp_q.push_back(32'h0011_2023);
    tick();
    dmem_write = 1'b1; dmem_addr = 32'h200; dmem_wdata = 32'h1234_5678; dmem_be = 4'b0011;
    bus_ack = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (w == 1) bus_ack = 1'b1;
      #1;
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_wdata, bus_be, iready, dvalid} !==
          {2'b11, 32'h200, 32'h1234_5678, 4'b0011, w == 1, 1'b0}) begin
        errors++; $display("FAIL store_cycle%0d: req=%b we=%b addr=%h wdata=%h be=%b iready=%b dvalid=%b",
                           w, bus_req, bus_we, bus_addr, bus_wdata, bus_be, iready, dvalid);
      end
      tick();
    end
    dmem_write = 1'b0; dmem_be = 4'hF; pc += 4; PCaddr = pc;
  endtask

  task automatic test_back_to_back();
    int kind, wf, we;
    logic [31:0] word, ld;
    for (int n = 0; n < 10; n++) begin
      kind = $urandom_range(0, 2); wf = $urandom_range(0, 2); we = $urandom_range(0, 3);
      word = $urandom; ld = $urandom;
      bus_ack = 1'b0;
      for (int w = 0; w < wf; w++) begin
        #1;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== pc || bus_be !== 4'hF || bus_we !== 1'b0) begin
          errors++; $display("FAIL b2b_fetch_wait: req=%b addr=%h be=%h we=%b expected 1/%h/f/0",
                             bus_req, bus_addr, bus_be, bus_we, pc);
        end
        tick();
      end
      bus_ack = 1'b1; bus_rdata = word; exp_q.push_back(word);
      tick();
      dmem_read = (kind == 1) || (kind == 2 && $urandom_range(0, 1) == 1);
      dmem_write = (kind == 2); dmem_addr = $urandom; dmem_wdata = $urandom; dmem_be = 4'($urandom);
      if (kind == 0) begin
        bus_ack = 1'($urandom); #1;
        checks++;
        if (iready !== 1'b1 || bus_req !== 1'b0) begin
          errors++; $display("FAIL b2b_alu: iready=%b req=%b expected 1/0", iready, bus_req);
        end
      end else begin
        bus_ack = 1'b0;
        for (int w = 0; w < we; w++) begin
          #1;
          checks++;
          if ({bus_req, bus_we, bus_addr, bus_be, iready} !== {1'b1, dmem_write, dmem_addr, dmem_be, 1'b0}) begin
            errors++; $display("FAIL b2b_mem_wait: req=%b we=%b addr=%h be=%h iready=%b",
                               bus_req, bus_we, bus_addr, bus_be, iready);
          end
          tick();
        end
        bus_ack = 1'b1; bus_rdata = ld;
        if (kind == 1) d_exp_q.push_back(ld);
        #1;
        checks++;
        if (iready !== 1'b1 || dvalid !== (kind == 1) || bus_we !== (kind == 2)) begin
          errors++; $display("FAIL b2b_mem_ack: iready=%b dvalid=%b we=%b kind=%0d", iready, dvalid, bus_we, kind);
        end
      end
      tick();
      dmem_read = 1'b0; dmem_write = 1'b0; pc += 4; PCaddr = pc;
    end
  endtask

  task automatic test_timeout();
    bus_ack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (bus_req !== 1'b1 || bus_err !== 1'b0) begin
        errors++; $display("FAIL timeout_wait%0d: req=%b err=%b expected 1/0", k, bus_req, bus_err);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      bus_ack = (k != 0); #1;
      checks++;
      if ({bus_err, bus_req, iready} !== 3'b100 || seq_state !== ERROR) begin
        errors++; $display("FAIL timeout_error%0d: err=%b req=%b iready=%b state=%0d expected 1/0/0/ERROR",
                           k, bus_err, bus_req, iready, seq_state);
      end
      tick();
    end
    nRST = 1'b0; bus_ack = 1'b0; #1;
    checks++;
    if (bus_err !== 1'b0 || seq_state !== IDLE || instr !== 32'h13) begin
      errors++; $display("FAIL timeout_reset: err=%b state=%0d instr=%h", bus_err, seq_state, instr);
    end
    pc = 32'h80; PCaddr = pc;
    tick(); nRST = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) tick();
    bus_ack = 1'b1; bus_rdata = 32'h00A0_0113; exp_q.push_back(32'h00A0_0113);
    tick(); #1;
    checks++;
    if (seq_state !== EXEC || bus_err !== 1'b0 || iready !== 1'b1) begin
      errors++; $display("FAIL timeout_ack_at_limit: state=%0d err=%b iready=%b expected EXEC/0/1",
                         seq_state, bus_err, iready);
    end
    tick(); pc += 4; PCaddr = pc;
  endtask

  task automatic test_halt();
    halt = 1'b1; bus_ack = 1'b0;
    tick();
    halt = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0000_0113; exp_q.push_back(32'h0000_0113);
    tick();
    tick(); pc += 4; PCaddr = pc; #1;
    checks++;
    if (seq_state !== FETCH || halted !== 1'b0 || bus_req !== 1'b1) begin
      errors++; $display("FAIL halt_fetch_only: state=%0d halted=%b req=%b expected FETCH/0/1",
                         seq_state, halted, bus_req);
    end
    halt = 1'b1; bus_rdata = 32'h0010_0073; exp_q.push_back(32'h0010_0073);
    tick(); #1;
    checks++;
    if (iready !== 1'b1 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_commit: iready=%b halted=%b expected 1/0", iready, halted);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({halted, bus_req, iready} !== 3'b100 || seq_state !== HALTED) begin
        errors++; $display("FAIL halt_hold%0d: halted=%b req=%b iready=%b state=%0d",
                           k, halted, bus_req, iready, seq_state);
      end
      tick();
    end
    nRST = 1'b0; halt = 1'b0; #1;
    checks++;
    if (seq_state !== IDLE || instr !== 32'h13 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_reset: state=%0d instr=%h halted=%b expected IDLE/00000013/0",
                         seq_state, instr, halted);
    end
  endtask

  task automatic test_reset_mid_access();
    pc = 32'h40; PCaddr = pc; bus_ack = 1'b1; bus_rdata = 32'h3000_2083;
    tick(); nRST = 1'b1;
    tick();
    tick();
    dmem_read = 1'b1; dmem_addr = 32'h300; bus_ack = 1'b0;
    tick(); #1;
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h300) begin
      errors++; $display("FAIL midrst_wait: req=%b addr=%h expected 1/300", bus_req, bus_addr);
    end
    #1; nRST = 1'b0; #1;
    checks++;
    if ({bus_req, iready, dvalid} !== 3'b000) begin
      errors++; $display("FAIL midrst_drop: req=%b iready=%b dvalid=%b expected 000", bus_req, iready, dvalid);
    end
    bus_ack = 1'b1; #1;
    checks++;
    if ({bus_req, iready, dvalid} !== 3'b000) begin
      errors++; $display("FAIL midrst_ack_ignored: req=%b iready=%b dvalid=%b expected 000",
                         bus_req, iready, dvalid);
    end
    tick(); nRST = 1'b1; dmem_read = 1'b0; bus_ack = 1'b0; #1;
    checks++;
    if (bus_req !== 1'b0 || seq_state !== IDLE) begin
      errors++; $display("FAIL midrst_idle: req=%b state=%0d expected 0/IDLE", bus_req, seq_state);
    end
    tick(); #1;
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h40 || instr !== 32'h13) begin
      errors++; $display("FAIL midrst_refetch: req=%b addr=%h instr=%h expected 1/40/00000013",
                         bus_req, bus_addr, instr);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_timeout();
    test_halt();
    test_reset_mid_access();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || d_exp_q.size() != 0) begin
      errors++; $display("FAIL queues_drained: commits left=%0d loads left=%0d expected 0/0",
                         exp_q.size(), d_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
